// File: rtl/io_pkg.sv
// Shared definitions for the UART transmitter: register offsets, STATUS layout, FSM states.
package io_pkg;

  localparam int unsigned DIV_W = 16;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_DIV    = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  // Bit of a STATUS write that clears the sticky overflow flag.
  localparam int unsigned STAT_OVF_BIT = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // STATUS register image; field order fixes the bit positions.
  typedef struct packed {
    logic [23:0] rsvd;
    logic [3:0]  count;
    logic        overflow;
    logic        empty;
    logic        full;
    logic        tx_active;
  } status_t;

  // A divisor of zero still yields a one-cycle bit period.
  function automatic logic [DIV_W-1:0] eff_period(input logic [DIV_W-1:0] div);
    return (div == '0) ? DIV_W'(1) : div;
  endfunction

endpackage

// File: rtl/io_uart_tx_if.sv
// Memory-mapped peripheral bus used by the UART transmitter.
interface io_uart_tx_if;
  logic        sel;
  logic [31:0] mem_addr;
  logic        mem_rstrb;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_rbusy;

  modport master (
    output sel, mem_addr, mem_rstrb, mem_wdata, mem_wmask,
    input  mem_rdata, mem_rbusy
  );

  modport slave (
    input  sel, mem_addr, mem_rstrb, mem_wdata, mem_wmask,
    output mem_rdata, mem_rbusy
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; power-of-two depth so pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_n;
  logic             full_q;
  logic             empty_q;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is still taken when a pop frees a slot this cycle.
  assign do_pop  = pop && !empty_q;
  assign do_push = push && (!full_q || do_pop);

  // Next occupancy.
  always_comb begin
    count_n = count_q;
    if (do_push && !do_pop) begin
      count_n = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_n = count_q - CW'(1);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointers, occupancy and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_n;
      full_q  <= (count_n == CW'(DEPTH));
      empty_q <= (count_n == '0);
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small transmit FIFO and programmable divisor.
module io_uart_tx
  import io_pkg::*;
#(
  parameter int unsigned DEFAULT_DIV = 104,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  io_uart_tx_if.slave bus,
  output logic        tx,
  output logic        tx_active
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [1:0]        off;
  logic              wr_c;
  logic              rd_c;
  logic              push_c;
  logic              pop_c;
  logic              ovf_clr_c;
  logic              div_wr_c;
  logic [7:0]        fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              overflow_q;
  logic [DIV_W-1:0]  div_q;
  logic [31:0]       rdata_q;
  logic [31:0]       rdata_c;
  status_t           status_c;

  tx_state_e         state_q, state_n;
  logic [DIV_W-1:0]  cyc_q, cyc_n;
  logic [DIV_W-1:0]  per_q, per_n;
  logic [2:0]        bit_q, bit_n;
  logic [7:0]        sh_q, sh_n;
  logic              tx_q, tx_n;
  logic              act_q;
  logic              bit_end_c;

  wire unused_bus_bits = &{1'b0, bus.mem_addr[31:4], bus.mem_addr[1:0],
                           bus.mem_wdata[31:16], bus.mem_wmask[3:2]};

  // Bus decode.
  assign off       = bus.mem_addr[3:2];
  assign wr_c      = bus.sel && (bus.mem_wmask != 4'b0000);
  assign rd_c      = bus.sel && bus.mem_rstrb;
  assign push_c    = wr_c && (off == OFF_DATA) && bus.mem_wmask[0];
  assign ovf_clr_c = wr_c && (off == OFF_STATUS) && bus.mem_wmask[0] && bus.mem_wdata[STAT_OVF_BIT];
  assign div_wr_c  = wr_c && (off == OFF_DIV);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (resetn),
    .push  (push_c),
    .wdata (bus.mem_wdata[7:0]),
    .pop   (pop_c),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Read data mux.
  always_comb begin
    status_c           = '0;
    status_c.count     = 4'(fifo_count);
    status_c.overflow  = overflow_q;
    status_c.empty     = fifo_empty;
    status_c.full      = fifo_full;
    status_c.tx_active = act_q;
    rdata_c            = '0;
    case (off)
      OFF_STATUS: rdata_c = status_c;
      OFF_DIV:    rdata_c = {16'b0, div_q};
      OFF_DATA:   rdata_c = '0;
      OFF_RSVD:   rdata_c = '0;
      default:    rdata_c = '0;
    endcase
  end

  // Control registers and registered read data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow_q <= 1'b0;
      div_q      <= DIV_W'(DEFAULT_DIV);
      rdata_q    <= '0;
    end else begin
      if (push_c && fifo_full && !pop_c) begin
        overflow_q <= 1'b1;
      end else if (ovf_clr_c) begin
        overflow_q <= 1'b0;
      end
      if (div_wr_c && bus.mem_wmask[0]) div_q[7:0]  <= bus.mem_wdata[7:0];
      if (div_wr_c && bus.mem_wmask[1]) div_q[15:8] <= bus.mem_wdata[15:8];
      if (rd_c) rdata_q <= rdata_c;
    end
  end

  // The current bit period length is captured at each bit start, so DIV writes apply at the next boundary.
  assign bit_end_c = (cyc_q == (per_q - DIV_W'(1)));

  // Transmit FSM next-state and line value.
  always_comb begin
    state_n = state_q;
    cyc_n   = cyc_q;
    per_n   = per_q;
    bit_n   = bit_q;
    sh_n    = sh_q;
    tx_n    = tx_q;
    pop_c   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tx_n = 1'b1;
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          state_n = ST_START;
          sh_n    = fifo_rdata;
          cyc_n   = '0;
          per_n   = eff_period(div_q);
          tx_n    = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end_c) begin
          state_n = ST_DATA;
          bit_n   = '0;
          cyc_n   = '0;
          per_n   = eff_period(div_q);
          tx_n    = sh_q[0];
        end else begin
          cyc_n = cyc_q + DIV_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_end_c) begin
          cyc_n = '0;
          per_n = eff_period(div_q);
          if (bit_q == 3'd7) begin
            state_n = ST_STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n = bit_q + 3'd1;
            sh_n  = {1'b0, sh_q[7:1]};
            tx_n  = sh_q[1];
          end
        end else begin
          cyc_n = cyc_q + DIV_W'(1);
        end
      end
      ST_STOP: begin
        if (bit_end_c) begin
          cyc_n = '0;
          if (!fifo_empty) begin
            pop_c   = 1'b1;
            state_n = ST_START;
            sh_n    = fifo_rdata;
            per_n   = eff_period(div_q);
            tx_n    = 1'b0;
          end else begin
            state_n = ST_IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          cyc_n = cyc_q + DIV_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  // Transmit FSM state register; reset aborts any frame and idles the line.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      per_q   <= DIV_W'(1);
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cyc_q   <= cyc_n;
      per_q   <= per_n;
      bit_q   <= bit_n;
      sh_q    <= sh_n;
      tx_q    <= tx_n;
      act_q   <= (state_n != ST_IDLE);
    end
  end

  assign tx            = tx_q;
  assign tx_active     = act_q;
  assign bus.mem_rdata = rdata_q;
  assign bus.mem_rbusy = 1'b0;

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed self-checking bench for io_uart_tx.
module tb_io_uart_tx;

  logic clk;
  logic resetn;
  logic tx;
  logic tx_active;
  int   errors;
  int   checks;
  logic [31:0] rd;
  logic cap_tx  [0:99];
  logic cap_act [0:99];
  logic [7:0] bytes3 [0:2];

  io_uart_tx_if bus_if ();

  io_uart_tx #(
    .DEFAULT_DIV (104),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus_if),
    .tx        (tx),
    .tx_active (tx_active)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus_if.sel       = 1'b0;
    bus_if.mem_rstrb = 1'b0;
    bus_if.mem_wmask = 4'h0;
  endtask

  task automatic bus_write(input int o, input logic [31:0] d, input logic [3:0] m);
    bus_if.sel       = 1'b1;
    bus_if.mem_addr  = 32'(o) << 2;
    bus_if.mem_rstrb = 1'b0;
    bus_if.mem_wdata = d;
    bus_if.mem_wmask = m;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_read(input int o, output logic [31:0] d);
    bus_if.sel       = 1'b1;
    bus_if.mem_addr  = 32'(o) << 2;
    bus_if.mem_rstrb = 1'b1;
    bus_if.mem_wmask = 4'h0;
    @(negedge clk);
    bus_idle();
    d = bus_if.mem_rdata;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
  endtask

  // Expected line level at cycle pos of a frame (0 = first start-bit cycle).
  function automatic logic exp_tx(input logic [7:0] b, input int per, input int pos);
    if (pos < per) return 1'b0;
    if (pos < 9 * per) return b[(pos - per) / per];
    return 1'b1;
  endfunction

  initial begin
    errors = 0;
    checks = 0;
    bytes3[0] = 8'hA1;
    bytes3[1] = 8'hB2;
    bytes3[2] = 8'hC3;
    bus_if.mem_addr  = '0;
    bus_if.mem_wdata = '0;
    bus_idle();
    resetn = 1'b1;
    #2 resetn = 1'b0;
    @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_active", 32'(tx_active), 32'd0);
    check("rst_rdata", bus_if.mem_rdata, 32'd0);
    check("rst_rbusy", 32'(bus_if.mem_rbusy), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    bus_read(1, rd);
    check("rst_status", rd, 32'h04);
    bus_read(2, rd);
    check("rst_div", rd, 32'd104);

    // Single frame timing at DIV=4
    bus_write(2, 32'd4, 4'h3);
    bus_write(0, 32'h55, 4'h1);
    check("resid_tx", 32'(tx), 32'd1);
    check("resid_active", 32'(tx_active), 32'd0);
    for (int i = 0; i < 44; i++) begin
      @(negedge clk);
      cap_tx[i]  = tx;
      cap_act[i] = tx_active;
    end
    for (int i = 0; i < 44; i++) begin
      check($sformatf("f55_tx_%0d", i), 32'(cap_tx[i]), 32'(exp_tx(8'h55, 4, i)));
      check($sformatf("f55_act_%0d", i), 32'(cap_act[i]), (i < 40) ? 32'd1 : 32'd0);
    end

    // Back-to-back frames at DIV=2
    bus_write(2, 32'd2, 4'h3);
    bus_write(0, 32'(bytes3[0]), 4'h1);
    for (int i = 0; i < 66; i++) begin
      if (i < 2) begin
        bus_if.sel       = 1'b1;
        bus_if.mem_addr  = 32'h0;
        bus_if.mem_wdata = 32'(bytes3[i + 1]);
        bus_if.mem_wmask = 4'h1;
      end else begin
        bus_idle();
      end
      @(negedge clk);
      cap_tx[i]  = tx;
      cap_act[i] = tx_active;
    end
    for (int i = 0; i < 66; i++) begin
      if (i < 60) begin
        check($sformatf("b2b_tx_%0d", i), 32'(cap_tx[i]), 32'(exp_tx(bytes3[i / 20], 2, i % 20)));
        check($sformatf("b2b_act_%0d", i), 32'(cap_act[i]), 32'd1);
      end else begin
        check($sformatf("b2b_idle_tx_%0d", i), 32'(cap_tx[i]), 32'd1);
        check($sformatf("b2b_idle_act_%0d", i), 32'(cap_act[i]), 32'd0);
      end
    end
    bus_read(1, rd);
    check("b2b_status", rd, 32'h04);

    // Overflow with DIV=100
    do_reset();
    bus_write(2, 32'd100, 4'h3);
    for (int i = 0; i < 6; i++) bus_write(0, 32'(8'h10 + i), 4'h1);
    bus_read(1, rd);
    check("ovf_status", rd, 32'h4B);
    bus_write(1, 32'h8, 4'h2);
    bus_read(1, rd);
    check("ovf_noclr_mask", rd, 32'h4B);
    bus_write(1, 32'h8, 4'h1);
    bus_read(1, rd);
    check("ovf_cleared", rd, 32'h43);
    bus_read(0, rd);
    check("data_reads_0", rd, 32'h0);

    // Register readback and access qualification
    do_reset();
    bus_write(2, 32'h1234, 4'h3);
    bus_read(2, rd);
    check("div_readback", rd, 32'h1234);
    check("rbusy_a", 32'(bus_if.mem_rbusy), 32'd0);
    bus_write(3, 32'hFFFF_FFFF, 4'hF);
    bus_read(3, rd);
    check("rsvd_reads_0", rd, 32'h0);
    bus_read(2, rd);
    check("div_after_rsvd", rd, 32'h1234);
    bus_if.mem_addr  = 32'h4;
    bus_if.mem_rstrb = 1'b1;
    bus_if.mem_wdata = 32'h1;
    bus_if.mem_wmask = 4'h0;
    repeat (3) @(negedge clk);
    bus_idle();
    check("rdata_hold_nosel", bus_if.mem_rdata, 32'h1234);
    bus_if.mem_addr  = 32'h0;
    bus_if.mem_wdata = 32'h77;
    bus_if.mem_wmask = 4'h1;
    @(negedge clk);
    bus_idle();
    bus_read(1, rd);
    check("nosel_write_ignored", rd, 32'h04);
    check("rbusy_b", 32'(bus_if.mem_rbusy), 32'd0);

    // Reset during DATA bit 3
    bus_write(2, 32'd4, 4'h3);
    bus_write(0, 32'hF0, 4'h1);
    repeat (18) @(negedge clk);
    check("mid_tx_low", 32'(tx), 32'd0);
    check("mid_active", 32'(tx_active), 32'd1);
    resetn = 1'b0;
    #1;
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_active", 32'(tx_active), 32'd0);
    check("mid_rst_rdata", bus_if.mem_rdata, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    bus_read(1, rd);
    check("post_rst_status", rd, 32'h04);
    bus_read(2, rd);
    check("post_rst_div", rd, 32'd104);
    repeat (5) @(negedge clk);
    check("post_rst_tx_idle", 32'(tx), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
